// File: rtl/code_transmitter_pkg.sv
// ============================================================================
// Module  : code_transmitter_pkg
// Brief   : Shared constants, Hamming(7,4) bit order and FSM states for the
//           serial code transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package code_transmitter_pkg;

  localparam int NIBBLE_BITS = 4;
  localparam int CODE_BITS   = 7;
  localparam int FRAME_BITS  = 8;
  localparam logic START_BIT = 1'b1;

  // Codeword bit positions: c[6:0] = {d3, d2, d1, p2, d0, p1, p0}
  localparam int HAM_P0 = 0;
  localparam int HAM_P1 = 1;
  localparam int HAM_D0 = 2;
  localparam int HAM_P2 = 3;
  localparam int HAM_D1 = 4;
  localparam int HAM_D2 = 5;
  localparam int HAM_D3 = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/code_transmitter_if.sv
// ============================================================================
// Module  : code_transmitter_if
// Brief   : Nibble handshake plus serial line and busy flag of the transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface code_transmitter_if;
  import code_transmitter_pkg::*;

  logic [NIBBLE_BITS-1:0] io_in_data;
  logic                   io_in_valid;
  logic                   io_in_ready;
  logic                   io_output;
  logic                   io_busy;

  modport master (
    output io_in_data,
    output io_in_valid,
    input  io_in_ready,
    input  io_output,
    input  io_busy
  );

  modport slave (
    input  io_in_data,
    input  io_in_valid,
    output io_in_ready,
    output io_output,
    output io_busy
  );

endinterface

`default_nettype wire

// File: rtl/code_transmitter_encoder.sv
// ============================================================================
// Module  : hamming74_encoder
// Brief   : Combinational Hamming(7,4) encoder, 4-bit nibble to 7-bit codeword.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming74_encoder
  import code_transmitter_pkg::*;
(
  input  logic [NIBBLE_BITS-1:0] i_data,
  output logic [CODE_BITS-1:0]   o_code
);

  always_comb begin
    o_code         = '0;
    o_code[HAM_P0] = i_data[0] ^ i_data[1] ^ i_data[3];
    o_code[HAM_P1] = i_data[0] ^ i_data[2] ^ i_data[3];
    o_code[HAM_P2] = i_data[1] ^ i_data[2] ^ i_data[3];
    o_code[HAM_D0] = i_data[0];
    o_code[HAM_D1] = i_data[1];
    o_code[HAM_D2] = i_data[2];
    o_code[HAM_D3] = i_data[3];
  end

endmodule

`default_nettype wire

// File: rtl/code_transmitter.sv
// ============================================================================
// Module  : code_transmitter
// Brief   : Hamming(7,4)-encodes a nibble and shifts out start bit + codeword
//           MSB first, followed by GAP_BITS zero bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module code_transmitter
  import code_transmitter_pkg::*;
#(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 3
) (
  input  logic               clock,
  input  logic               reset,
  code_transmitter_if.slave  link
);

  localparam int CYC_W   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_MAX = (GAP_BITS > FRAME_BITS) ? GAP_BITS : FRAME_BITS;
  localparam int BIT_W   = $clog2(BIT_MAX);

  localparam logic [CYC_W-1:0] C_CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0] C_DATA_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] C_GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  state_t                  r_state;
  logic [CYC_W-1:0]        r_cyc_cnt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic                    r_out;
  logic                    r_busy;

  logic [CODE_BITS-1:0]    w_code;
  logic [FRAME_BITS-1:0]   w_frame;
  logic                    w_last_cyc;
  logic                    w_end_ready;
  logic                    w_ready;
  logic                    w_xfer;

  hamming74_encoder u_encoder (
    .i_data (link.io_in_data),
    .o_code (w_code)
  );

  assign w_frame    = {START_BIT, w_code};
  assign w_last_cyc = (r_cyc_cnt == C_CYC_LAST);

  // The next nibble may be taken in the very last clock of the frame+gap.
  generate
    if (GAP_BITS == 0) begin : g_no_gap
      assign w_end_ready = (r_state == ST_DATA) && (r_bit_cnt == C_DATA_LAST) && w_last_cyc;
    end else begin : g_gap
      assign w_end_ready = (r_state == ST_GAP) && (r_bit_cnt == C_GAP_LAST) && w_last_cyc;
    end
  endgenerate

  assign w_ready = reset && ((r_state == ST_IDLE) || w_end_ready);
  assign w_xfer  = link.io_in_valid && w_ready;

  assign link.io_in_ready = w_ready;
  assign link.io_output   = r_out;
  assign link.io_busy     = r_busy;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cyc_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_out     <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_xfer) begin
      // r_shift holds the bits still to send, next one at the MSB.
      r_state   <= ST_DATA;
      r_cyc_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= {w_frame[FRAME_BITS-2:0], 1'b0};
      r_out     <= w_frame[FRAME_BITS-1];
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end
        ST_DATA: begin
          if (w_last_cyc) begin
            r_cyc_cnt <= '0;
            if (r_bit_cnt == C_DATA_LAST) begin
              r_bit_cnt <= '0;
              r_out     <= 1'b0;
              if (GAP_BITS == 0) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_GAP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_out     <= r_shift[FRAME_BITS-1];
              r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (w_last_cyc) begin
            r_cyc_cnt <= '0;
            if (r_bit_cnt == C_GAP_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
